// File: rtl/raster_sample_fifo_if.sv
// -----------------------------------------------------------------------------
// raster_sample_fifo_if
//
// Bundles the raster-facing write handshake, the readout-facing FWFT read
// port and the status outputs of raster_sample_fifo.
//
// Handshake semantics (write side, four-phase):
//   The raster drives in_data and raises in_ready. The FIFO captures the word
//   and raises in_valid on the next edge (only if it has room). in_valid stays
//   high until the raster drops in_ready; then in_valid falls on the next
//   edge. in_data must stay stable while in_ready is high. While the FIFO is
//   full in_valid stays low and the raster simply waits.
//   Read side: out_data is meaningful while out_valid=1. A one-cycle out_pop
//   strobe with out_valid=1 retires the head word; out_pop with out_valid=0
//   only sets the sticky underflow_err. clear is a one-cycle flush strobe.
//
// Modports:
//   master : raster + readout side (drives in_data, in_ready, out_pop, clear)
//   slave  : the FIFO itself
// -----------------------------------------------------------------------------
interface raster_sample_fifo_if #(
   parameter int DAT_WID   = 24,
   parameter int DEPTH_WID = 10
);
   logic [DAT_WID-1:0]   in_data;
   logic                 in_ready;
   logic                 in_valid;
   logic [DAT_WID-1:0]   out_data;
   logic                 out_valid;
   logic                 out_pop;
   logic                 clear;
   logic [DEPTH_WID:0]   count;
   logic [DEPTH_WID:0]   high_water;
   logic                 full;
   logic                 underflow_err;

   modport master (
      output in_data,
      output in_ready,
      output out_pop,
      output clear,
      input  in_valid,
      input  out_data,
      input  out_valid,
      input  count,
      input  high_water,
      input  full,
      input  underflow_err
   );

   modport slave (
      input  in_data,
      input  in_ready,
      input  out_pop,
      input  clear,
      output in_valid,
      output out_data,
      output out_valid,
      output count,
      output high_water,
      output full,
      output underflow_err
   );
endinterface

// File: rtl/raster_sample_fifo.sv
// -----------------------------------------------------------------------------
// raster_sample_fifo
//
// Buffers signed ADC samples from the raster scanner and presents them to the
// readout side as a first-word-fall-through queue.
//
// Ports:
//   clk           system clock
//   rst_L         synchronous, active-low reset
//   bus           raster_sample_fifo_if.slave: write handshake (in_data,
//                 in_ready, in_valid), FWFT read port (out_data, out_valid,
//                 out_pop), clear strobe and status (count, high_water, full,
//                 underflow_err)
//   wr_state_dbg  current write-handshake state (0 = IDLE, 1 = ACK)
//
// Datapath:
//   RAM (registered read) -> rd stage (rd_data_q/rd_valid_q) -> out register
//   A word written at edge N is read into the rd stage at N+1 and shown at
//   out_data at N+2. The rd stage acts as a one-word prefetch so that
//   back-to-back pops see a new head word every cycle.
// -----------------------------------------------------------------------------
module raster_sample_fifo #(
   parameter int DAT_WID   = 24,
   parameter int DEPTH_WID = 10
) (
   input  logic                   clk,
   input  logic                   rst_L,
   raster_sample_fifo_if.slave    bus,
   output logic                   wr_state_dbg
);

   localparam int            CW       = DEPTH_WID + 1;
   localparam int unsigned   DEPTH    = 1 << DEPTH_WID;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic {
      WR_IDLE = 1'b0,
      WR_ACK  = 1'b1
   } wr_state_e;

   // storage
   logic [DAT_WID-1:0]   mem [DEPTH];

   // write-handshake FSM
   wr_state_e            state_q, state_d;
   logic                 in_valid_q, in_valid_d;

   // pointers and occupancy
   logic [DEPTH_WID-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_WID-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        count_q, count_d;
   logic [CW-1:0]        high_water_q, high_water_d;
   logic                 underflow_q, underflow_d;

   // read pipeline
   logic                 rd_valid_q, rd_valid_d;
   logic [DAT_WID-1:0]   rd_data_q;
   logic                 out_valid_q, out_valid_d;
   logic [DAT_WID-1:0]   out_data_q, out_data_d;

   // per-cycle decisions
   logic                 full;
   logic                 wr_en;
   logic                 pop_ok;
   logic                 out_free;
   logic                 rd_free;
   logic                 rd_issue;
   logic [CW-1:0]        ram_cnt;

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      full   = (count_q == FULL_CNT);
      pop_ok = bus.out_pop && out_valid_q;

      // full is judged on the registered count, so a pop in the same cycle
      // does not open the slot until the next edge.
      wr_en  = rst_L && (state_q == WR_IDLE) && bus.in_ready && !full && !bus.clear;

      // Words still sitting in RAM: everything stored minus what has already
      // moved into the rd stage or the output register.
      ram_cnt  = count_q - CW'(rd_valid_q) - CW'(out_valid_q);

      // Output register can take a new word when empty or when its word is
      // being retired this cycle; the rd stage frees up when it is empty or
      // hands its word to the output register.
      out_free = !out_valid_q || pop_ok;
      rd_free  = !rd_valid_q || out_free;
      rd_issue = rst_L && rd_free && (ram_cnt != '0) && !bus.clear;

      // defaults: hold
      state_d      = state_q;
      in_valid_d   = in_valid_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      high_water_d = high_water_q;
      underflow_d  = underflow_q;
      rd_valid_d   = rd_valid_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;

      if (bus.clear) begin
         // clear beats any write or pop in the same cycle; out_data keeps its
         // stale value but out_valid masks it.
         state_d      = WR_IDLE;
         in_valid_d   = 1'b0;
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         count_d      = '0;
         high_water_d = '0;
         underflow_d  = 1'b0;
         rd_valid_d   = 1'b0;
         out_valid_d  = 1'b0;
      end else begin
         // write handshake
         case (state_q)
            WR_IDLE: begin
               if (wr_en) begin
                  state_d    = WR_ACK;
                  in_valid_d = 1'b1;
               end
            end
            WR_ACK: begin
               if (!bus.in_ready) begin
                  state_d    = WR_IDLE;
                  in_valid_d = 1'b0;
               end
            end
            default: begin
               state_d    = WR_IDLE;
               in_valid_d = 1'b0;
            end
         endcase

         if (wr_en) begin
            wr_ptr_d = wr_ptr_q + DEPTH_WID'(1);
         end

         if (rd_issue) begin
            rd_ptr_d = rd_ptr_q + DEPTH_WID'(1);
         end

         // read pipeline advance
         if (out_free) begin
            out_valid_d = rd_valid_q;
            if (rd_valid_q) begin
               out_data_d = rd_data_q;
            end
         end
         if (rd_free) begin
            rd_valid_d = rd_issue;
         end

         // occupancy: write and accepted pop in the same cycle cancel
         count_d = count_q + CW'(wr_en) - CW'(pop_ok);

         // track against the new count so the peak shows on the same edge
         if (count_d > high_water_q) begin
            high_water_d = count_d;
         end

         if (bus.out_pop && !out_valid_q) begin
            underflow_d = 1'b1;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Control and status registers (includes the write FSM)
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_L) begin
         state_q      <= WR_IDLE;
         in_valid_q   <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         high_water_q <= '0;
         underflow_q  <= 1'b0;
         rd_valid_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         in_valid_q   <= in_valid_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         high_water_q <= high_water_d;
         underflow_q  <= underflow_d;
         rd_valid_q   <= rd_valid_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
      end
   end

   // --------------------------------------------------------------------------
   // Simple dual-port RAM with registered read. Never reads the slot being
   // written in the same cycle: rd_issue only fires for words already counted
   // in ram_cnt, and a write cannot happen when the RAM is completely full.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr_q] <= bus.in_data;
      end
      if (rd_issue) begin
         rd_data_q <= mem[rd_ptr_q];
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign bus.in_valid      = in_valid_q;
   assign bus.out_data      = out_data_q;
   assign bus.out_valid     = out_valid_q;
   assign bus.count         = count_q;
   assign bus.high_water    = high_water_q;
   assign bus.full          = full;
   assign bus.underflow_err = underflow_q;
   assign wr_state_dbg      = (state_q == WR_ACK);

endmodule

// File: tb/tb_raster_sample_fifo.sv
// -----------------------------------------------------------------------------
// tb_raster_sample_fifo
//
// Drives raster_sample_fifo (DEPTH_WID=3, 8 words) through directed scenarios
// and a randomized phase. A queue-based reference model tracks stored words
// and the edge on which each was written; a word is visible at the output
// once it is the head and two edges have passed since its write.
// -----------------------------------------------------------------------------
module tb_raster_sample_fifo;

   localparam int DAT_WID   = 24;
   localparam int DEPTH_WID = 3;
   localparam int DEPTH     = 1 << DEPTH_WID;

   // ---------------------------------------------------------------- clock/reset
   logic clk   = 1'b0;
   logic rst_L = 1'b0;
   logic wr_state_dbg;

   always #5 clk = ~clk;

   raster_sample_fifo_if #(.DAT_WID(DAT_WID), .DEPTH_WID(DEPTH_WID)) bus ();

   raster_sample_fifo #(
      .DAT_WID   (DAT_WID),
      .DEPTH_WID (DEPTH_WID)
   ) dut (
      .clk          (clk),
      .rst_L        (rst_L),
      .bus          (bus),
      .wr_state_dbg (wr_state_dbg)
   );

   // ---------------------------------------------------------------- scoreboard
   logic [DAT_WID-1:0] exp_q[$];
   int                 wr_edge_q[$];
   logic [DAT_WID-1:0] rd_log[$];
   int                 cyc;
   bit                 m_ack;
   int                 m_hw;
   bit                 m_uf;
   int                 checks;
   int                 failures;

   // stimulus knobs
   int                 req_pct, pop_pct, uf_pct, clr_pct;
   int                 samples_left;
   bit                 seq_data;
   logic [DAT_WID-1:0] seq_val;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_out_valid();
      return (exp_q.size() > 0) && (wr_edge_q[0] + 3 <= cyc);
   endfunction

   // Apply the rules of one clock edge to the model, using the inputs that
   // were stable across that edge.
   task automatic model_step();
      bit mv, do_pop, do_wr;
      if (!rst_L || bus.clear) begin
         exp_q.delete();
         wr_edge_q.delete();
         m_ack = 0;
         m_hw  = 0;
         m_uf  = 0;
      end else begin
         mv     = m_out_valid();
         do_pop = bus.out_pop && mv;
         if (bus.out_pop && !mv) m_uf = 1;
         do_wr  = !m_ack && bus.in_ready && (exp_q.size() < DEPTH);
         if (m_ack && !bus.in_ready) m_ack = 0;
         else if (do_wr)             m_ack = 1;
         if (do_pop) begin
            void'(exp_q.pop_front());
            void'(wr_edge_q.pop_front());
         end
         if (do_wr) begin
            exp_q.push_back(bus.in_data);
            wr_edge_q.push_back(cyc);
         end
         if (exp_q.size() > m_hw) m_hw = exp_q.size();
      end
      cyc++;
   endtask

   task automatic compare_all();
      bit mv;
      mv = m_out_valid();
      check_val("in_valid",      bus.in_valid,      m_ack);
      check_val("wr_state_dbg",  wr_state_dbg,      m_ack);
      check_val("out_valid",     bus.out_valid,     mv);
      if (mv) check_val("out_data", bus.out_data,   exp_q[0]);
      check_val("count",         bus.count,         exp_q.size());
      check_val("high_water",    bus.high_water,    m_hw);
      check_val("full",          bus.full,          exp_q.size() == DEPTH);
      check_val("underflow_err", bus.underflow_err, m_uf);
   endtask

   // ---------------------------------------------------------------- driver tasks
   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic auto_drive();
      if (bus.in_ready && bus.in_valid) begin
         bus.in_ready = 1'b0;
      end else if (!bus.in_ready && !bus.in_valid && samples_left > 0 &&
                   $urandom_range(99) < req_pct) begin
         bus.in_ready = 1'b1;
         bus.in_data  = seq_data ? seq_val : DAT_WID'($urandom);
         seq_val++;
         samples_left--;
      end
      if (bus.out_valid) begin
         bus.out_pop = ($urandom_range(99) < pop_pct);
         if (bus.out_pop) rd_log.push_back(bus.out_data);
      end else begin
         bus.out_pop = ($urandom_range(99) < uf_pct);
      end
      bus.clear = ($urandom_range(99) < clr_pct);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         auto_drive();
         step();
      end
      bus.out_pop = 1'b0;
      bus.clear   = 1'b0;
   endtask

   task automatic pulse_clear();
      bus.clear = 1'b1;
      step();
      bus.clear = 1'b0;
   endtask

   task automatic drain(input string tag);
      samples_left = 0;
      req_pct = 0; pop_pct = 100; uf_pct = 0; clr_pct = 0;
      if (bus.in_ready) begin
         bus.in_ready = 1'b0;
         step();
      end
      for (int i = 0; i < 4 * DEPTH + 8 && exp_q.size() > 0; i++) begin
         auto_drive();
         step();
      end
      bus.out_pop = 1'b0;
      check_val(tag, bus.count, 0);
   endtask

   // ---------------------------------------------------------------- main
   initial begin
      bus.in_data  = '0;
      bus.in_ready = 1'b0;
      bus.out_pop  = 1'b0;
      bus.clear    = 1'b0;
      cyc = 0; m_ack = 0; m_hw = 0; m_uf = 0;
      checks = 0; failures = 0;
      samples_left = 0; seq_data = 0; seq_val = '0;
      req_pct = 0; pop_pct = 0; uf_pct = 0; clr_pct = 0;

      // reset values
      rst_L = 1'b0;
      step();
      step();
      check_val("rst_out_data", bus.out_data, 0);
      check_val("rst_count",    bus.count,    0);
      rst_L = 1'b1;

      // single sample
      bus.in_data  = 24'hFFF123;
      bus.in_ready = 1'b1;
      step();
      check_val("t1_in_valid_1cyc", bus.in_valid, 1);
      bus.in_ready = 1'b0;
      step();
      check_val("t1_out_valid_early", bus.out_valid, 0);
      step();
      check_val("t1_out_valid_2cyc", bus.out_valid, 1);
      check_val("t1_out_data",       bus.out_data,  24'hFFF123);
      check_val("t1_count",          bus.count,     1);
      bus.out_pop = 1'b1;
      step();
      bus.out_pop = 1'b0;
      check_val("t1_count_after_pop", bus.count,     0);
      check_val("t1_out_valid_after", bus.out_valid, 0);

      // ordering and pointer wrap: 20 words 0..19 with interleaved pops
      pulse_clear();
      rd_log.delete();
      seq_data = 1; seq_val = '0; samples_left = 20;
      req_pct = 100; pop_pct = 60; uf_pct = 0; clr_pct = 0;
      run(120);
      check_val("t2_all_sent", samples_left, 0);
      drain("t2_drain");
      check_val("t2_hw_le_depth", bus.high_water <= DEPTH, 1);
      check_val("t2_read_len", rd_log.size(), 20);
      for (int i = 0; i < rd_log.size() && i < 20; i++) begin
         check_val($sformatf("t2_order_%0d", i), rd_log[i], i);
      end

      // full backpressure
      pulse_clear();
      seq_data = 1; seq_val = 24'h000100; samples_left = DEPTH;
      req_pct = 100; pop_pct = 0;
      run(2 * DEPTH + 4);
      check_val("t3_full",  bus.full,  1);
      check_val("t3_count", bus.count, DEPTH);
      bus.in_data  = 24'h0000AA;
      bus.in_ready = 1'b1;
      step(); step(); step();
      check_val("t3_stall_in_valid", bus.in_valid, 0);
      bus.out_pop = 1'b1;
      step();
      bus.out_pop = 1'b0;
      check_val("t3_full_drop",     bus.full,     0);
      check_val("t3_not_yet_taken", bus.in_valid, 0);
      step();
      check_val("t3_accept",     bus.in_valid, 1);
      check_val("t3_full_again", bus.full,     1);
      bus.in_ready = 1'b0;
      drain("t3_drain");

      // underflow
      pulse_clear();
      bus.out_pop = 1'b1;
      step();
      bus.out_pop = 1'b0;
      check_val("t4_underflow", bus.underflow_err, 1);
      check_val("t4_count",     bus.count,         0);
      step(); step();
      check_val("t4_sticky", bus.underflow_err, 1);
      pulse_clear();
      check_val("t4_cleared", bus.underflow_err, 0);

      // clear mid-handshake
      seq_data = 1; seq_val = 24'h000200; samples_left = 5;
      req_pct = 100; pop_pct = 0;
      run(14);
      check_val("t5_count5", bus.count, 5);
      bus.in_data  = 24'h5A5A5A;
      bus.in_ready = 1'b1;
      step();
      check_val("t5_in_ack", bus.in_valid, 1);
      bus.clear = 1'b1;
      step();
      bus.clear = 1'b0;
      check_val("t5_clr_count",    bus.count,      0);
      check_val("t5_clr_hw",       bus.high_water, 0);
      check_val("t5_clr_in_valid", bus.in_valid,   0);
      step();
      check_val("t5_reaccept_count", bus.count,    1);
      check_val("t5_reaccept_valid", bus.in_valid, 1);
      bus.in_ready = 1'b0;
      drain("t5_drain");

      // reset mid-operation
      pulse_clear();
      seq_data = 1; seq_val = 24'h800000; samples_left = 4;
      req_pct = 100; pop_pct = 0;
      run(12);
      check_val("t6_count4", bus.count, 4);
      rst_L = 1'b0;
      step();
      rst_L = 1'b1;
      check_val("t6_rst_count",     bus.count,      0);
      check_val("t6_rst_out_valid", bus.out_valid,  0);
      check_val("t6_rst_out_data",  bus.out_data,   0);
      check_val("t6_rst_hw",        bus.high_water, 0);
      seq_data = 0; samples_left = 3;
      req_pct = 100; pop_pct = 100;
      run(20);
      drain("t6_drain");

      // randomized traffic with occasional clears and underflow pops
      seq_data = 0; samples_left = 1500;
      req_pct = 70; pop_pct = 55; uf_pct = 3; clr_pct = 1;
      run(3000);
      drain("t7_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/raster_sample_fifo.md
# raster_sample_fifo

Buffers signed ADC samples produced by the raster scanner and hands them to the readout side (CPU/bus bridge) one word at a time. Sits directly downstream of the raster state machine's FIFO port: it completes the raster's four-phase sample handshake, applies backpressure when storage is full, and presents a first-word-fall-through read interface with occupancy, high-water and error status.

## Interface
Parameters:
- DAT_WID, 24, sample width (equals raster MAX_ADC_DATA_WID)
- DEPTH_WID, 10, log2 of storage depth (1024 words)

Ports:
- clk  in  1  system clock
- rst_L  in  1  synchronous, active-low reset
- in_data  in  DAT_WID  signed sample from raster
- in_ready  in  1  raster asserts: in_data holds a new sample
- in_valid  out  1  block asserts: sample captured; held until in_ready falls
- out_data  out  DAT_WID  head-of-queue sample
- out_valid  out  1  out_data holds a valid head word
- out_pop  in  1  one-cycle strobe: consume head word
- clear  in  1  one-cycle strobe: flush contents and errors
- count  out  DEPTH_WID+1  words stored, including head word
- high_water  out  DEPTH_WID+1  maximum count since reset/clear
- full  out  1  count == 2^DEPTH_WID
- underflow_err  out  1  sticky: out_pop seen while out_valid=0

## Operation
- Write-side FSM, states IDLE, ACK:
  - IDLE: if in_ready=1 and full=0, write in_data at wr_ptr, wr_ptr+1, go to ACK with in_valid=1. If full=1, stay in IDLE with in_valid=0; the raster stalls (no sample is dropped).
  - ACK: hold in_valid=1 until in_ready=0, then in_valid=0 and back to IDLE. No new write occurs in ACK.
- Storage: simple dual-port RAM with registered read, 2^DEPTH_WID words; wr_ptr, rd_ptr are DEPTH_WID bits, wrap modulo depth.
- Read side: first-word-fall-through. A prefetch stage loads the head word into the out_data register whenever out_valid=0 or out_pop=1 and RAM is non-empty.
- out_pop with out_valid=1: retire head word; next word (if any) shown without a bubble when already prefetched, else after RAM latency.
- out_pop with out_valid=0: ignored for data; set underflow_err.
- count: +1 on write, −1 on accepted pop, unchanged when both in the same cycle.
- high_water: updated to count whenever count exceeds it.
- clear: pointers, count, high_water, underflow_err, out_valid to 0; write FSM returns to IDLE with in_valid=0 (a raster holding in_ready re-handshakes and its sample is written next cycle). clear wins over simultaneous write/pop.
- Data passes bit-exact; no sign manipulation.

## Timing
- Reset values: in_valid=0, out_valid=0, out_data=0, count=0, high_water=0, full=0, underflow_err=0; FSM in IDLE.
- in_ready rising (block empty, IDLE) → write and in_valid=1 on next clock edge (1 cycle).
- Write to out_valid on empty queue: 2 cycles (RAM read + output register).
- Sustained: one sample per 2 cycles minimum from handshake (IDLE/ACK); pops sustain 1 word/cycle while stored.
- full asserts the cycle count reaches 2^DEPTH_WID; deasserts the cycle after a pop frees a slot; a stalled in_ready is accepted on the following cycle.
- Simultaneous write and pop at full: pop accepted; write deferred one cycle (full evaluated before the pop).
- rst_L low mid-handshake: in_valid drops on the next edge; contents discarded.

## Test plan
- Single sample: in_data=24'hFFF123, pulse handshake → in_valid high 1 cycle after in_ready, out_valid 2 cycles after write, out_data=24'hFFF123, count=1; out_pop → count=0, out_valid=0.
- Ordering and wrap: DEPTH_WID=3, write 20 words 0..19 interleaved with pops → read sequence exactly 0..19, pointers wrap twice, high_water ≤ 8.
- Full backpressure: DEPTH_WID=3, write 8 words without popping → full=1, 9th in_ready held with in_valid=0; one pop → 9th accepted 1 cycle after full drops, final read order intact.
- Underflow: out_pop on empty → underflow_err=1 sticky, count stays 0; clear → underflow_err=0.
- Clear mid-handshake: 5 stored, clear while in ACK → count=0, high_water=0, in_valid=0; held in_ready re-accepted, count=1.
- Reset mid-operation: rst_L low for 1 cycle with 4 stored → all outputs at reset values next edge; subsequent write/read works.
